// File: rtl/ldpc_frame_sched.sv
// LDPC frame scheduler: loads channel LLRs into the decoder, starts a decode,
// waits for completion or timeout, then drains hard-decision bits and status.
//
// state   | meaning
// IDLE    | waiting for first LLR beat of a frame
// LOAD    | accepting LLR beats, writing them to the decoder
// START   | one-cycle decode start pulse
// WAIT    | decoder running, timeout counter active
// RD_REQ  | present read index to the decoder
// RD_HOLD | offer decoded bit to the sink until accepted
// STAT    | one-cycle frame status pulse
module ldpc_frame_sched #(
  parameter int N            = 204,
  parameter int LOG2N        = 8,
  parameter int LLR_W        = 16,
  parameter int LOG2MAX_ITER = 5,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LLR_W-1:0]        in_llr,
  input  logic                    in_last,
  output logic                    dec_wr_en,
  output logic [LOG2N-1:0]        dec_wr_addr,
  output logic [LLR_W-1:0]        dec_wr_data,
  output logic                    dec_start,
  input  logic                    dec_done,
  input  logic                    dec_success,
  input  logic [LOG2MAX_ITER-1:0] dec_iter,
  output logic [LOG2N-1:0]        dec_rd_addr,
  input  logic                    dec_rd_bit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic                    out_last,
  output logic                    stat_valid,
  output logic                    stat_success,
  output logic [LOG2MAX_ITER-1:0] stat_iter,
  output logic                    stat_timeout,
  output logic                    frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RD_REQ, RD_HOLD, STAT} state_t;

  state_t           state;
  logic [LOG2N-1:0] beat_cnt;
  logic [LOG2N-1:0] rd_idx;
  logic [TW-1:0]    wait_cnt;
  logic             rd_first;
  logic             bit_q;

  // Read data arrives in the first RD_HOLD cycle; pass it through then, hold it after.
  assign out_bit = rd_first ? dec_rd_bit : bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      rd_idx       <= '0;
      wait_cnt     <= '0;
      rd_first     <= 1'b0;
      bit_q        <= 1'b0;
      in_ready     <= 1'b1;
      dec_wr_en    <= 1'b0;
      dec_wr_addr  <= '0;
      dec_wr_data  <= '0;
      dec_start    <= 1'b0;
      dec_rd_addr  <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      stat_valid   <= 1'b0;
      stat_success <= 1'b0;
      stat_iter    <= '0;
      stat_timeout <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      dec_wr_en  <= 1'b0;
      dec_start  <= 1'b0;
      stat_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            dec_wr_en   <= 1'b1;
            dec_wr_addr <= beat_cnt;
            dec_wr_data <= in_llr;
            if (beat_cnt == LAST_IDX && in_last) begin
              state        <= START;
              in_ready     <= 1'b0;
              dec_start    <= 1'b1;
              stat_timeout <= 1'b0;
              beat_cnt     <= '0;
            end else if (beat_cnt == LAST_IDX || in_last) begin
              // Misaligned frame end: drop the frame and resync on the next beat.
              state     <= IDLE;
              frame_err <= 1'b1;
              beat_cnt  <= '0;
            end else begin
              state    <= LOAD;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        START: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (dec_done) begin
            stat_success <= dec_success;
            stat_iter    <= dec_iter;
            rd_idx       <= '0;
            dec_rd_addr  <= '0;
            state        <= RD_REQ;
          end else if (wait_cnt == TO_LAST) begin
            // Give up on the decoder but still drain its hard decisions.
            stat_timeout <= 1'b1;
            stat_success <= 1'b0;
            stat_iter    <= '1;
            rd_idx       <= '0;
            dec_rd_addr  <= '0;
            state        <= RD_REQ;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_REQ: begin
          state     <= RD_HOLD;
          out_valid <= 1'b1;
          out_last  <= (rd_idx == LAST_IDX);
          rd_first  <= 1'b1;
        end
        RD_HOLD: begin
          if (rd_first) begin
            bit_q    <= dec_rd_bit;
            rd_first <= 1'b0;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (rd_idx == LAST_IDX) begin
              state      <= STAT;
              stat_valid <= 1'b1;
            end else begin
              rd_idx      <= rd_idx + 1'b1;
              dec_rd_addr <= rd_idx + 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        STAT: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ldpc_frame_sched.md
LDPC_FRAME_SCHED -- requirements
Module: ldpc_frame_sched

Interface
REQ-001 SHALL have parameter N, default 204, code length in bits.
REQ-002 SHALL have parameter LOG2N, default 8, index width.
REQ-003 SHALL have parameter LLR_W, default 16, LLR width (INT+FRAC).
REQ-004 SHALL have parameter LOG2MAX_ITER, default 5, iteration-count width.
REQ-005 SHALL have parameter TIMEOUT, default 65535, max WAIT cycles.
REQ-006 SHALL have these ports, each as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  LLR beat valid.
- in_ready  out  1  LLR beat accepted.
- in_llr  in  LLR_W  channel LLR.
- in_last  in  1  final beat of frame.
- dec_wr_en  out  1  decoder LLR write strobe.
- dec_wr_addr  out  LOG2N  decoder LLR write index.
- dec_wr_data  out  LLR_W  decoder LLR write data.
- dec_start  out  1  one-cycle decode start pulse.
- dec_done  in  1  decoder finished, one-cycle pulse.
- dec_success  in  1  zero syndrome, valid with dec_done.
- dec_iter  in  LOG2MAX_ITER  iterations used, valid with dec_done.
- dec_rd_addr  out  LOG2N  decoded-bit read index.
- dec_rd_bit  in  1  decoded bit, 1-cycle read latency.
- out_valid  out  1  decoded bit valid.
- out_ready  in  1  sink accepts bit.
- out_bit  out  1  decoded bit.
- out_last  out  1  bit index N-1.
- stat_valid  out  1  one-cycle frame status pulse.
- stat_success  out  1  decode success.
- stat_iter  out  LOG2MAX_ITER  iterations used.
- stat_timeout  out  1  WAIT exceeded TIMEOUT.
- frame_err  out  1  one-cycle pulse, in_last misaligned.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, START, WAIT, RD_REQ, RD_HOLD, STAT.
REQ-008 IDLE: in_ready=1; first in_valid beat SHALL be written at addr 0 and enter LOAD.
REQ-009 LOAD: in_ready=1; each in_valid beat SHALL assert dec_wr_en the same cycle, addr = beat count, data = in_llr, registered outputs allowed one-cycle latency but order preserved.
REQ-010 Beat N-1 with in_last=1 SHALL go to START; in_last on beat k<N-1, or beat N-1 without in_last, SHALL pulse frame_err, discard the frame and return to IDLE.
REQ-011 START: dec_start=1 for exactly one cycle, in_ready=0, then WAIT.
REQ-012 WAIT: cycle counter SHALL start at 0; dec_done SHALL latch dec_success/dec_iter and go to RD_REQ with read index 0.
REQ-013 If the counter reaches TIMEOUT without dec_done, SHALL set stat_timeout=1, stat_success=0, stat_iter=all-ones, and go to RD_REQ (hard-decision bits drained anyway).
REQ-014 RD_REQ: drive dec_rd_addr=index for one cycle, then RD_HOLD.
REQ-015 RD_HOLD: capture dec_rd_bit into out_bit on entry, out_valid=1, out_last=(index==N-1); hold all out_* stable until out_ready.
REQ-016 On out_valid&&out_ready: if index<N-1, increment index and go to RD_REQ; else go to STAT.
REQ-017 Throughput in drain SHALL be one bit per two cycles with out_ready held high.
REQ-018 STAT: stat_valid=1 for one cycle with latched values, then IDLE; stat_timeout cleared on next frame's START.
REQ-019 in_ready SHALL be 0 in all states except IDLE and LOAD; input beats with in_ready=0 are not consumed.
REQ-020 dec_done outside WAIT SHALL be ignored.
REQ-021 Beat and index counters SHALL be LOG2N bits and never exceed N-1.

Reset
REQ-022 rst SHALL return FSM to IDLE and zero all counters, the latched status and all outputs except in_ready, which is 1, overriding any concurrent input or a mid-frame state.
REQ-023 With rst held, no dec_wr_en, dec_start, out_valid, stat_valid or frame_err SHALL assert.

Verification
REQ-024 N=12, 12 beats LLR=k, last on beat 11 -> dec_wr_addr 0..11 data 0..11, one dec_start pulse.
REQ-025 dec_done after 40 cycles, success=1, iter=7, rd_bit=addr[0], out_ready=1 -> 12 bits 0,1,0,1,... on alternate cycles, out_last on bit 11, stat_valid with success=1, iter=7.
REQ-026 in_last on beat 5 -> frame_err pulse, no dec_start, IDLE; next clean frame decodes normally.
REQ-027 TIMEOUT=100, no dec_done -> drain starts cycle 101 of WAIT, stat_timeout=1, stat_iter=31.
REQ-028 out_ready low 10 cycles at bit 3 -> out_bit and out_valid stable, no bit lost or duplicated.
REQ-029 rst asserted in WAIT and again in RD_HOLD -> next cycle IDLE, in_ready=1, all other outputs 0.
